// File: rtl/fir_coef_loader.sv
// Queues completed coefficient writes with auto-assigned tap addresses and
// drains them into the shared coefficient RAM during engine-granted windows.
module fir_coef_loader #(
  parameter int NUM_FILTERS      = 4,
  parameter int FILTER_ADDR_BITS = 2,
  parameter int TAP_ADDR_BITS    = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    coef_wr_stb,
  input  logic [7:0]                              filter_select,
  input  logic [7:0]                              taps_per_filter,
  input  logic [7:0]                              coef_lsb,
  input  logic [7:0]                              coef_msb,
  input  logic                                    clear_err,
  input  logic                                    ram_grant,
  output logic                                    coef_ram_req,
  output logic                                    coef_ram_we,
  output logic [FILTER_ADDR_BITS+TAP_ADDR_BITS-1:0] coef_ram_addr,
  output logic [15:0]                             coef_ram_wdata,
  output logic [TAP_ADDR_BITS-1:0]                tap_ptr,
  output logic                                    fifo_empty,
  output logic                                    fifo_full,
  output logic                                    load_done,
  output logic                                    overflow_err,
  output logic                                    sel_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = FILTER_ADDR_BITS + TAP_ADDR_BITS;
  localparam int EW = AW + 16;

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t                   state, state_nxt;
  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, count_nxt;
  logic [7:0]               sel_q;
  logic [TAP_ADDR_BITS-1:0] tap_cur, last_tap;
  logic [AW-1:0]            addr_q;
  logic [15:0]              wdata_q;
  logic                     sel_bad, push, pop, drop_ovf, wrap;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));

  // A filter change restarts tap numbering in the same cycle it is seen.
  assign tap_cur  = (filter_select != sel_q) ? '0 : tap_ptr;
  assign last_tap = (taps_per_filter == 8'd0) ? '1
                                              : TAP_ADDR_BITS'(taps_per_filter - 8'd1);
  assign wrap     = (tap_cur == last_tap);

  assign sel_bad  = (filter_select >= 8'(NUM_FILTERS));
  assign push     = coef_wr_stb && !sel_bad && !fifo_full;
  assign drop_ovf = coef_wr_stb && !sel_bad && fifo_full;

  assign coef_ram_req = (state != IDLE);
  assign coef_ram_we  = (state == WRITE) && ram_grant;
  assign pop          = coef_ram_we;
  assign count_nxt    = count + CW'(push) - CW'(pop);

  // Address/data follow the head entry only while writing, else hold the last write.
  assign coef_ram_addr  = pop ? mem[rd_ptr][EW-1:16] : addr_q;
  assign coef_ram_wdata = pop ? mem[rd_ptr][15:0]    : wdata_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = REQ;
      REQ:     if (ram_grant) state_nxt = WRITE;
      WRITE: begin
        if (!ram_grant)             state_nxt = REQ;
        else if (count_nxt == '0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sel_q        <= '0;
      tap_ptr      <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
      sel_err      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      sel_q     <= filter_select;
      load_done <= push && wrap;
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        tap_ptr <= wrap ? '0 : tap_cur + TAP_ADDR_BITS'(1);
      end else if (!coef_wr_stb) begin
        tap_ptr <= tap_cur;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        addr_q  <= coef_ram_addr;
        wdata_q <= coef_ram_wdata;
      end
      if (drop_ovf)       overflow_err <= 1'b1;
      else if (clear_err) overflow_err <= 1'b0;
      if (coef_wr_stb && sel_bad) sel_err <= 1'b1;
      else if (clear_err)         sel_err <= 1'b0;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {filter_select[FILTER_ADDR_BITS-1:0], tap_cur, coef_msb, coef_lsb};
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: vector table plus hand sequences, RAM writes
// checked against a scoreboard queue.
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        coef_wr_stb = 1'b0;
  logic [7:0]  filter_select = '0;
  logic [7:0]  taps_per_filter = '0;
  logic [7:0]  coef_lsb = '0;
  logic [7:0]  coef_msb = '0;
  logic        clear_err = 1'b0;
  logic        ram_grant = 1'b0;
  logic        coef_ram_req, coef_ram_we;
  logic [9:0]  coef_ram_addr;
  logic [15:0] coef_ram_wdata;
  logic [7:0]  tap_ptr;
  logic        fifo_empty, fifo_full, load_done, overflow_err, sel_err;

  fir_coef_loader dut (
    .clk(clk), .reset_n(reset_n), .coef_wr_stb(coef_wr_stb),
    .filter_select(filter_select), .taps_per_filter(taps_per_filter),
    .coef_lsb(coef_lsb), .coef_msb(coef_msb), .clear_err(clear_err),
    .ram_grant(ram_grant), .coef_ram_req(coef_ram_req), .coef_ram_we(coef_ram_we),
    .coef_ram_addr(coef_ram_addr), .coef_ram_wdata(coef_ram_wdata),
    .tap_ptr(tap_ptr), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .load_done(load_done), .overflow_err(overflow_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  fsel;
    logic [15:0] coef;
    logic        acc;
    logic [9:0]  addr;
    logic [7:0]  tap;
    logic        ld;
    logic        serr;
  } vec_t;

  vec_t        vecs [7];
  logic [25:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          wr_count = 0;
  int          cnt = 0;
  int          first_we = -1;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One call = one clock cycle: inputs applied at negedge, returns just after posedge.
  task automatic drive(input logic s, input logic [7:0] fs, input logic [15:0] c,
                       input logic g, input logic clr);
    @(negedge clk);
    coef_wr_stb   = s;
    filter_select = fs;
    coef_msb      = c[15:8];
    coef_lsb      = c[7:0];
    ram_grant     = g;
    clear_err     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, filter_select, 16'h0, 1'b1, 1'b0);
      if (exp_q.size() == 0 && fifo_empty && !coef_ram_req) break;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_req_low", coef_ram_req, 1'b0);
  endtask

  // RAM-side monitor, sampled mid-cycle after inputs settle.
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (coef_ram_we === 1'b1) begin
        chk("we_without_grant", ram_grant, 1'b1);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got addr %0h data %0h with nothing expected",
                   coef_ram_addr, coef_ram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("ram_write", {coef_ram_addr, coef_ram_wdata}, e);
        end
        wr_count++;
        if (first_we < 0) first_we = cnt;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, w0;
    vecs[0] = '{8'd1, 16'h1234, 1'b1, 10'h100, 8'd1, 1'b0, 1'b0};
    vecs[1] = '{8'd1, 16'h5678, 1'b1, 10'h101, 8'd2, 1'b0, 1'b0};
    vecs[2] = '{8'd1, 16'h9ABC, 1'b1, 10'h102, 8'd0, 1'b1, 1'b0};
    vecs[3] = '{8'd0, 16'h1111, 1'b1, 10'h000, 8'd1, 1'b0, 1'b0};
    vecs[4] = '{8'd0, 16'h2222, 1'b1, 10'h001, 8'd2, 1'b0, 1'b0};
    vecs[5] = '{8'd2, 16'h3333, 1'b1, 10'h200, 8'd1, 1'b0, 1'b0};
    vecs[6] = '{8'd7, 16'h4444, 1'b0, 10'h000, 8'd1, 1'b0, 1'b1};

    // Reset state
    reset_n = 1'b0;
    drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    chk("rst_fifo_empty", fifo_empty, 1'b1);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_tap_ptr", tap_ptr, 8'd0);
    chk("rst_req", coef_ram_req, 1'b0);
    chk("rst_we", coef_ram_we, 1'b0);
    chk("rst_addr", coef_ram_addr, 10'd0);
    chk("rst_wdata", coef_ram_wdata, 16'd0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_overflow_err", overflow_err, 1'b0);
    chk("rst_sel_err", sel_err, 1'b0);

    // Basic load, 3 taps on filter 1, grant held high
    taps_per_filter = 8'd3;
    first_we = -1;
    t0 = cnt;
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].acc) exp_q.push_back({vecs[i].addr, vecs[i].coef});
      drive(1'b1, vecs[i].fsel, vecs[i].coef, 1'b1, 1'b0);
      chk("basic_tap_ptr", tap_ptr, vecs[i].tap);
      chk("basic_load_done", load_done, vecs[i].ld);
    end
    drive(1'b0, 8'd1, 16'h0, 1'b1, 1'b0);
    chk("basic_load_done_one_cycle", load_done, 1'b0);
    wait_drain();
    chk("basic_first_we_latency", first_we - t0, 3);
    chk("basic_write_count", wr_count, 3);

    // Grant starvation: 5 strobes into a 4-deep FIFO
    taps_per_filter = 8'd8;
    w0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({10'h100 + 10'(i), 16'hA000 + 16'(i)});
      drive(1'b1, 8'd1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    end
    chk("starve_fifo_full", fifo_full, 1'b1);
    chk("starve_overflow_err", overflow_err, 1'b1);
    chk("starve_tap_ptr", tap_ptr, 8'd4);
    chk("starve_req", coef_ram_req, 1'b1);
    chk("starve_no_writes", wr_count - w0, 0);
    wait_drain();
    chk("starve_write_count", wr_count - w0, 4);
    chk("starve_err_sticky", overflow_err, 1'b1);
    drive(1'b0, 8'd1, 16'h0, 1'b0, 1'b1);
    chk("starve_clear_err", overflow_err, 1'b0);

    // Grant toggling while in WRITE with two entries
    w0 = wr_count;
    exp_q.push_back({10'h104, 16'hB004});
    drive(1'b1, 8'd1, 16'hB004, 1'b0, 1'b0);
    exp_q.push_back({10'h105, 16'hB005});
    drive(1'b1, 8'd1, 16'hB005, 1'b0, 1'b0);
    chk("toggle_req", coef_ram_req, 1'b1);
    drive(1'b0, 8'd1, 16'h0, 1'b1, 1'b0);
    chk("toggle_enter_write", wr_count - w0, 0);
    drive(1'b0, 8'd1, 16'h0, 1'b1, 1'b0);
    chk("toggle_first_write", wr_count - w0, 1);
    drive(1'b0, 8'd1, 16'h0, 1'b0, 1'b0);
    chk("toggle_gap_no_write", wr_count - w0, 1);
    chk("toggle_gap_req", coef_ram_req, 1'b1);
    drive(1'b0, 8'd1, 16'h0, 1'b1, 1'b0);
    chk("toggle_reenter_no_write", wr_count - w0, 1);
    drive(1'b0, 8'd1, 16'h0, 1'b1, 1'b0);
    chk("toggle_second_write", wr_count - w0, 2);
    chk("toggle_queue_empty", exp_q.size(), 0);
    chk("toggle_idle", coef_ram_req, 1'b0);

    // Filter switch and invalid filter select
    for (int i = 3; i < 7; i++) begin
      if (vecs[i].acc) exp_q.push_back({vecs[i].addr, vecs[i].coef});
      drive(1'b1, vecs[i].fsel, vecs[i].coef, 1'b1, 1'b0);
      chk("switch_tap_ptr", tap_ptr, vecs[i].tap);
      chk("switch_sel_err", sel_err, vecs[i].serr);
    end
    wait_drain();
    chk("switch_no_overflow", overflow_err, 1'b0);
    drive(1'b1, 8'd7, 16'h5555, 1'b1, 1'b1);
    chk("sel_set_wins_over_clear", sel_err, 1'b1);
    drive(1'b0, 8'd7, 16'h0, 1'b1, 1'b1);
    chk("sel_clear", sel_err, 1'b0);

    // Simultaneous push/pop, then full with coincident pop
    taps_per_filter = 8'd0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({10'h300 + 10'(i), 16'hC000 + 16'(i)});
      drive(1'b1, 8'd3, 16'hC000 + 16'(i), 1'b0, 1'b0);
    end
    drive(1'b0, 8'd3, 16'h0, 1'b1, 1'b0);
    exp_q.push_back({10'h303, 16'hC003});
    drive(1'b1, 8'd3, 16'hC003, 1'b1, 1'b0);
    chk("pushpop_not_full", fifo_full, 1'b0);
    chk("pushpop_not_empty", fifo_empty, 1'b0);
    exp_q.push_back({10'h304, 16'hC004});
    drive(1'b1, 8'd3, 16'hC004, 1'b0, 1'b0);
    chk("pushpop_occupancy_was_3", fifo_full, 1'b1);
    chk("pushpop_tap_ptr", tap_ptr, 8'd5);
    drive(1'b0, 8'd3, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 8'd3, 16'hDEAD, 1'b1, 1'b0);
    chk("full_pop_drop_overflow", overflow_err, 1'b1);
    chk("full_pop_after_not_full", fifo_full, 1'b0);
    chk("full_pop_tap_unchanged", tap_ptr, 8'd5);
    wait_drain();

    // Reset mid-drain with three entries pending
    taps_per_filter = 8'd8;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'd2, 16'hE000 + 16'(i), 1'b0, 1'b0);
    chk("middrain_req", coef_ram_req, 1'b1);
    reset_n = 1'b0;
    drive(1'b0, 8'd2, 16'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    chk("middrain_fifo_empty", fifo_empty, 1'b1);
    chk("middrain_tap_ptr", tap_ptr, 8'd0);
    chk("middrain_req_low", coef_ram_req, 1'b0);
    chk("middrain_we_low", coef_ram_we, 1'b0);
    chk("middrain_overflow_cleared", overflow_err, 1'b0);
    w0 = wr_count;
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd2, 16'h0, 1'b1, 1'b0);
    chk("middrain_no_writes", wr_count - w0, 0);
    chk("middrain_still_empty", fifo_empty, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
